// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259-style PIC control logic.
// Covers the init/INTA state enums and the ICW/OCW decode constants.
package pic_pkg;

  typedef enum logic [2:0] {
    INIT_UNINIT = 3'd0,
    INIT_W_ICW2 = 3'd1,
    INIT_W_ICW3 = 3'd2,
    INIT_W_ICW4 = 3'd3,
    INIT_READY  = 3'd4
  } init_st_t;

  typedef enum logic [1:0] {
    INTA_IDLE = 2'd0,
    INTA_ACK1 = 2'd1,
    INTA_ACK2 = 2'd2
  } inta_st_t;

  // ICW1 / OCW2 bit positions
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_ID   = 4;
  localparam int OCW2_EOI  = 5;

  // ICW4 bit positions
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_BUF  = 3;

endpackage

// File: rtl/pic_edge_detect.sv
// Strobe edge detector: registers a one-cycle delayed copy of the level so a
// held-high strobe yields a single rising event, plus a falling event.
module pic_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!reset) r_q <= 1'b0;
    else        r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;
  assign o_fall = ~i_sig & r_q;

endmodule

// File: rtl/pic_ctrl_logic.sv
// Control logic of an 8259-style PIC: ICW sequencing, mode flags, CPU INT
// request, two-pulse INTA handshake, EOI pulse generation and bus enable.
module pic_ctrl_logic
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inta,
  input  logic [7:0] D,
  input  logic       a0,
  input  logic       wrflg,
  input  logic       rdflag,
  input  logic [7:0] R,
  input  logic [2:0] rwadr,
  input  logic [2:0] Y,
  input  logic       S,
  input  logic       CLsig,
  input  logic [7:0] Mask,
  input  logic [7:0] isr,
  input  logic [7:0] irr,
  input  logic       isprior,
  // INT pin; named intr because int is a reserved word
  output logic       intr,
  output logic       ino,
  output logic       en,
  output logic       buff,
  output logic       LTIM,
  output logic       eoi,
  output logic       ar,
  output init_st_t   o_dbg_init_state,
  output inta_st_t   o_dbg_inta_state
);

  init_st_t   r_init_st;
  inta_st_t   r_inta_st;
  logic       r_single, r_ic4, r_ltim, r_buff, r_ar, r_ino;
  logic       r_int, r_en, r_eoi;
  logic [2:0] r_y;

  logic w_wr_rise, w_wr_fall, w_inta_rise, w_inta_fall;
  logic w_icw1, w_wr_data, w_ocw2_eoi, w_auto_eoi, w_ack_drive;
  logic w_unused;

  pic_edge_detect u_wr_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (wrflg),
    .o_rise (w_wr_rise),
    .o_fall (w_wr_fall)
  );

  pic_edge_detect u_inta_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (inta),
    .o_rise (w_inta_rise),
    .o_fall (w_inta_fall)
  );

  assign w_icw1     = w_wr_rise & ~a0 & D[ICW1_ID];
  assign w_wr_data  = w_wr_rise & a0;
  assign w_ocw2_eoi = w_wr_rise & ~a0 & (D[ICW1_ID:ICW1_LTIM] == 2'b00) &
                      D[OCW2_EOI] & (r_init_st == INIT_READY);
  assign w_auto_eoi = (r_inta_st == INTA_ACK2) & w_inta_fall & r_ar;
  // Drive the bus for the second INTA pulse, tracking the level as it will be
  // after this edge so en follows that pulse exactly.
  assign w_ack_drive = (((r_inta_st == INTA_ACK1) & w_inta_rise) |
                        ((r_inta_st == INTA_ACK2) & inta)) &
                       (r_single | S | CLsig);

  // Reserved / status-only inputs and the captured level have no output effect.
  assign w_unused = ^{R, rwadr, isr, r_y, D[7:6], D[2], w_wr_fall};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_init_st <= INIT_UNINIT;
      r_inta_st <= INTA_IDLE;
      r_single  <= 1'b0;
      r_ic4     <= 1'b0;
      r_ltim    <= 1'b0;
      r_buff    <= 1'b0;
      r_ar      <= 1'b0;
      r_ino     <= 1'b0;
      r_int     <= 1'b0;
      r_en      <= 1'b0;
      r_eoi     <= 1'b0;
      r_y       <= 3'd0;
    end else if (w_icw1) begin
      // ICW1 restarts initialization from any state and aborts any acknowledge.
      r_ltim    <= D[ICW1_LTIM];
      r_single  <= D[ICW1_SNGL];
      r_ic4     <= D[ICW1_IC4];
      r_buff    <= 1'b0;
      r_ar      <= 1'b0;
      r_ino     <= 1'b0;
      r_int     <= 1'b0;
      r_en      <= 1'b0;
      r_eoi     <= 1'b0;
      r_init_st <= INIT_W_ICW2;
      r_inta_st <= INTA_IDLE;
    end else begin
      r_eoi <= w_ocw2_eoi | w_auto_eoi;
      r_en  <= w_ack_drive | (rdflag & r_ino);

      if (w_wr_data) begin
        case (r_init_st)
          INIT_W_ICW2: begin
            if (!r_single) begin
              r_init_st <= INIT_W_ICW3;
            end else if (r_ic4) begin
              r_init_st <= INIT_W_ICW4;
            end else begin
              r_init_st <= INIT_READY;
              r_ino     <= 1'b1;
            end
          end
          INIT_W_ICW3: begin
            if (r_ic4) begin
              r_init_st <= INIT_W_ICW4;
            end else begin
              r_init_st <= INIT_READY;
              r_ino     <= 1'b1;
            end
          end
          INIT_W_ICW4: begin
            r_buff    <= D[ICW4_BUF];
            r_ar      <= D[ICW4_AEOI];
            r_init_st <= INIT_READY;
            r_ino     <= 1'b1;
          end
          default: ;
        endcase
      end

      case (r_inta_st)
        INTA_IDLE: begin
          if (w_inta_rise & r_ino) begin
            r_inta_st <= INTA_ACK1;
            r_int     <= 1'b0;
            r_y       <= Y;
          end else begin
            r_int <= r_ino & isprior & (|(irr & ~Mask));
          end
        end
        INTA_ACK1: begin
          r_int <= 1'b0;
          if (w_inta_rise) r_inta_st <= INTA_ACK2;
        end
        INTA_ACK2: begin
          r_int <= 1'b0;
          if (w_inta_fall) r_inta_st <= INTA_IDLE;
        end
        default: begin
          r_int     <= 1'b0;
          r_inta_st <= INTA_IDLE;
        end
      endcase
    end
  end

  assign intr             = r_int;
  assign ino              = r_ino;
  assign en               = r_en;
  assign buff             = r_buff;
  assign LTIM             = r_ltim;
  assign eoi              = r_eoi;
  assign ar               = r_ar;
  assign o_dbg_init_state = r_init_st;
  assign o_dbg_inta_state = r_inta_st;

endmodule

// File: tb/tb_pic_ctrl_logic.sv
// Bench for pic_ctrl_logic: directed vector table, hand-written corner
// sequences, then randomized traffic checked against an abstract model.
module tb_pic_ctrl_logic;
  import pic_pkg::*;

  logic       clk;
  logic       reset, inta, a0, wrflg, rdflag, S, CLsig, isprior;
  logic [7:0] D, R, Mask, isr, irr;
  logic [2:0] rwadr, Y;
  logic       intr, ino, en, buff, LTIM, eoi, ar;
  init_st_t   dbg_init;
  inta_st_t   dbg_inta;

  pic_ctrl_logic dut (
    .clk(clk), .reset(reset), .inta(inta), .D(D), .a0(a0), .wrflg(wrflg),
    .rdflag(rdflag), .R(R), .rwadr(rwadr), .Y(Y), .S(S), .CLsig(CLsig),
    .Mask(Mask), .isr(isr), .irr(irr), .isprior(isprior),
    .intr(intr), .ino(ino), .en(en), .buff(buff), .LTIM(LTIM), .eoi(eoi),
    .ar(ar), .o_dbg_init_state(dbg_init), .o_dbg_inta_state(dbg_inta)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Initialization is a list of ICW numbers still owed; acknowledge progress
  // is a count of INTA rising edges seen (0, 1 or 2).
  int   m_todo[$];
  logic m_seen, m_single, m_ltim, m_buff, m_ar, m_ino, m_int, m_en, m_eoi;
  int   m_acks;
  logic p_wr, p_ia;

  task automatic model_step();
    logic wr_r, ia_r, ia_f, ino_old, ar_old;
    int   nxt;
    wr_r = wrflg & ~p_wr;
    ia_r = inta & ~p_ia;
    ia_f = ~inta & p_ia;
    if (!reset) begin
      m_todo.delete();
      {m_seen, m_single, m_ltim, m_buff, m_ar, m_ino, m_int, m_en, m_eoi} = '0;
      m_acks = 0;
      p_wr   = 1'b0;
      p_ia   = 1'b0;
      return;
    end
    p_wr    = wrflg;
    p_ia    = inta;
    ino_old = m_ino;
    ar_old  = m_ar;
    m_eoi   = 1'b0;
    if (wr_r && !a0 && D[4]) begin
      m_seen = 1'b1;
      m_todo.delete();
      m_todo.push_back(2);
      if (!D[1]) m_todo.push_back(3);
      if (D[0])  m_todo.push_back(4);
      m_ltim   = D[3];
      m_single = D[1];
      {m_buff, m_ar, m_ino, m_int, m_en} = '0;
      m_acks = 0;
      return;
    end
    if (wr_r && a0 && m_seen && m_todo.size() > 0) begin
      nxt = m_todo.pop_front();
      if (nxt == 4) begin
        m_buff = D[3];
        m_ar   = D[1];
      end
    end
    if (wr_r && !a0 && ino_old && D[5:3] == 3'b100) m_eoi = 1'b1;
    m_ino = m_seen && (m_todo.size() == 0);
    if (m_acks == 0) begin
      if (ia_r && ino_old) begin
        m_acks = 1;
        m_int  = 1'b0;
      end else begin
        m_int = ino_old && isprior && ((irr & ~Mask) != 8'h00);
      end
    end else if (m_acks == 1) begin
      m_int = 1'b0;
      if (ia_r) m_acks = 2;
    end else begin
      m_int = 1'b0;
      if (ia_f) begin
        m_acks = 0;
        if (ar_old) m_eoi = 1'b1;
      end
    end
    m_en = (m_acks == 2 && inta && (m_single || S || CLsig)) || (rdflag && ino_old);
  endtask

  function automatic logic [6:0] model_vec();
    return {m_int, m_ino, m_en, m_buff, m_ltim, m_eoi, m_ar};
  endfunction

  // ---------------- driver / checker ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {intr, ino, en, buff, LTIM, eoi, ar};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: int/ino/en/buff/ltim/eoi/ar got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wr_pulse(input logic a, input logic [7:0] d);
    wrflg = 1'b1; a0 = a; D = d;
    tick();
    wrflg = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, ia, wr, a, rd, s, cl, isp;
    logic [7:0] d, mask, irq;
    logic [6:0] exp;   // {int, ino, en, buff, ltim, eoi, ar}
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, ia, wr, a, input logic [7:0] d,
                     input logic rd, s, cl, input logic [7:0] mask, irq,
                     input logic isp, input logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.ia = ia; v.wr = wr; v.a = a; v.d = d; v.rd = rd;
    v.s = s; v.cl = cl; v.mask = mask; v.irq = irq; v.isp = isp; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    //   rst ia wr a0 D      rd S  CL Mask   irr    isp exp
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000000);  // reset
    add(1, 1, 1, 0, 8'hAA, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000000);  // no init, not ICW1
    add(1, 1, 1, 0, 8'hAA, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000000);
    add(1, 0, 0, 0, 8'hAA, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000000);
    add(1, 0, 1, 0, 8'h1B, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000100);  // ICW1 single+IC4+LTIM
    add(1, 0, 0, 0, 8'h1B, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000100);
    add(1, 0, 1, 1, 8'h20, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000100);  // ICW2
    add(1, 0, 0, 1, 8'h20, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0000100);
    add(1, 0, 1, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0101101);  // ICW4 buf+aeoi
    add(1, 0, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b1101101);  // int raised
    add(1, 0, 0, 1, 8'h0B, 0, 1, 0, 8'h04, 8'h04, 1, 7'b0101101);  // masked
    add(1, 0, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b1101101);
    add(1, 1, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b0101101);  // INTA 1 rise
    add(1, 1, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b0101101);
    add(1, 0, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b0101101);
    add(1, 1, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b0111101);  // INTA 2, en
    add(1, 1, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h04, 1, 7'b0111101);
    add(1, 0, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h00, 1, 7'b0101111);  // auto EOI
    add(1, 0, 0, 1, 8'h0B, 0, 1, 0, 8'h00, 8'h00, 1, 7'b0101101);
    add(1, 0, 1, 0, 8'h20, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0101111);  // OCW2 EOI
    add(1, 0, 0, 0, 8'h20, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0101101);
    add(1, 0, 0, 0, 8'h20, 1, 1, 0, 8'h00, 8'h00, 0, 7'b0111101);  // read enable
    add(1, 0, 0, 0, 8'h20, 0, 1, 0, 8'h00, 8'h00, 0, 7'b0101101);
    add(1, 0, 1, 0, 8'h11, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0000000);  // ICW1 cascade+IC4
    add(1, 0, 0, 0, 8'h11, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0000000);
    add(1, 0, 1, 1, 8'h20, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0000000);  // ICW2
    add(1, 0, 0, 1, 8'h20, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0000000);
    add(1, 0, 1, 1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0000000);  // ICW3
    add(1, 0, 0, 1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0000000);
    add(1, 0, 1, 1, 8'h01, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0100000);  // ICW4
    add(1, 0, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 7'b1100000);
    add(1, 1, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 7'b0100000);  // slave, CL=0
    add(1, 0, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 7'b0100000);
    add(1, 1, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 7'b0100000);  // no en
    add(1, 0, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 7'b0100000);  // no auto EOI
    add(1, 0, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 7'b1100000);
    add(1, 0, 0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0100000);
    add(1, 0, 0, 1, 8'h01, 0, 0, 1, 8'h00, 8'h01, 1, 7'b1100000);  // slave, CL=1
    add(1, 1, 0, 1, 8'h01, 0, 0, 1, 8'h00, 8'h01, 1, 7'b0100000);
    add(1, 0, 0, 1, 8'h01, 0, 0, 1, 8'h00, 8'h01, 1, 7'b0100000);
    add(1, 1, 0, 1, 8'h01, 0, 0, 1, 8'h00, 8'h01, 1, 7'b0110000);  // en
    add(1, 0, 0, 1, 8'h01, 0, 0, 1, 8'h00, 8'h00, 0, 7'b0100000);
    add(1, 0, 1, 1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0100000);  // OCW1 ignored
    add(1, 0, 0, 1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0100000);
    add(1, 0, 1, 0, 8'h0A, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0100000);  // OCW3 no EOI
    add(1, 0, 0, 0, 8'h0A, 0, 0, 0, 8'h00, 8'h00, 0, 7'b0100000);

    {reset, inta, wrflg, a0, rdflag, S, CLsig, isprior} = '0;
    {D, R, Mask, isr, irr, rwadr, Y} = '0;

    foreach (vecs[i]) begin
      reset = vecs[i].rst; inta = vecs[i].ia; wrflg = vecs[i].wr; a0 = vecs[i].a;
      D = vecs[i].d; rdflag = vecs[i].rd; S = vecs[i].s; CLsig = vecs[i].cl;
      Mask = vecs[i].mask; irr = vecs[i].irq; isprior = vecs[i].isp;
      isr = 8'($urandom); R = 8'($urandom); rwadr = 3'($urandom); Y = 3'($urandom);
      tick();
      check($sformatf("tab%0d", i), vecs[i].exp);
    end

    // Reset while the acknowledge is in its first pulse.
    S = 1'b1; CLsig = 1'b0; irr = 8'h01; isprior = 1'b1; Mask = 8'h00;
    tick();            check("seqA_int", 7'b1100000);
    inta = 1'b1; tick(); check("seqA_ack1", 7'b0100000);
    reset = 1'b0; tick(); check("seqA_reset", 7'b0000000);
    reset = 1'b1; inta = 1'b0; tick(); check("seqA_after_reset", 7'b0000000);
    inta = 1'b1; tick(); check("seqA_inta_ignored", 7'b0000000);
    inta = 1'b0; tick(); check("seqA_idle", 7'b0000000);

    // ICW1 arriving on the same edge as the second INTA rise aborts the ack.
    irr = 8'h00; isprior = 1'b0;
    wr_pulse(1'b0, 8'h17);
    wr_pulse(1'b1, 8'h20);
    wr_pulse(1'b1, 8'h02);               check("seqB_ready", 7'b0100001);
    irr = 8'h01; isprior = 1'b1; tick(); check("seqB_int", 7'b1100001);
    inta = 1'b1; tick();                 check("seqB_ack1", 7'b0100001);
    inta = 1'b0; tick();                 check("seqB_gap", 7'b0100001);
    inta = 1'b1; wrflg = 1'b1; a0 = 1'b0; D = 8'h1A;
    tick();                              check("seqB_icw1_abort", 7'b0000100);
    inta = 1'b0; wrflg = 1'b0; tick();   check("seqB_no_eoi", 7'b0000100);
    wrflg = 1'b1; a0 = 1'b1; D = 8'h20; tick(); check("seqB_icw2_ready", 7'b0100100);
    wrflg = 1'b0; tick();                check("seqB_reinit_int", 7'b1100100);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 99) != 0);
      wrflg   = ($urandom_range(0, 5) == 0);
      a0      = 1'($urandom_range(0, 1));
      D       = 8'($urandom);
      if (!a0) begin
        case ($urandom_range(0, 3))
          0:       D[4] = 1'b1;
          1:       D = {D[7:6], 3'b100, D[2:0]};
          default: D[4] = 1'b0;
        endcase
      end
      if ($urandom_range(0, 2) == 0) inta = ~inta;
      rdflag  = ($urandom_range(0, 3) == 0);
      S       = 1'($urandom_range(0, 1));
      CLsig   = 1'($urandom_range(0, 1));
      Mask    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      irr     = 8'($urandom);
      isprior = 1'($urandom_range(0, 1));
      isr = 8'($urandom); R = 8'($urandom); rwadr = 3'($urandom); Y = 3'($urandom);
      tick();
      check($sformatf("rand%0d", i), model_vec());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pic_ctrl_logic.md
Name: pic_ctrl_logic

Overview:
Control-logic block of an 8259-style programmable interrupt controller.
- Decodes ICW/OCW writes from the data-bus buffer and sequences initialization.
- Holds the mode flags: LTIM, buffered mode, auto-EOI.
- Raises the CPU interrupt request and runs the two-pulse INTA handshake.
- Generates EOI pulses.
- Sits between the read/write logic, the priority resolver and the IRR/ISR/IMR registers.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- inta  in  1  interrupt acknowledge from CPU, active-high level.
- D  in  8  internal data bus, write data.
- a0  in  1  address bit A0.
- wrflg  in  1  write strobe from R/W logic, active-high level.
- rdflag  in  1  read strobe from R/W logic, active-high level.
- R  in  8  resolver request vector; reserved, accepted and ignored.
- rwadr  in  3  read register select; reserved, accepted and ignored.
- Y  in  3  resolved IR level index; captured at first INTA into an internal register, no output effect.
- S  in  1  SP/EN: 1 = master, 0 = slave.
- CLsig  in  1  cascade match: slave addressed by master's cascade code.
- Mask  in  8  IMR contents.
- isr  in  8  in-service register contents.
- irr  in  8  interrupt request register contents.
- isprior  in  1  resolver reports an unmasked request with priority above the current ISR.
- int  out  1  interrupt request to CPU.
- ino  out  1  initialization complete (operational).
- en  out  1  data-bus driver enable.
- buff  out  1  buffered mode (ICW4 bit 3).
- LTIM  out  1  level-triggered mode (ICW1 bit 3).
- eoi  out  1  one-cycle end-of-interrupt pulse.
- ar  out  1  auto-EOI mode (ICW4 bit 1).

Behaviour:
- All outputs registered.
- Reset (reset=0 at a clk edge): all outputs 0, init FSM = UNINIT, INTA FSM = IDLE, internal single/ic4 flags 0.
- Strobe detection:
  - wrflg and inta act on their rising edge, using a 1-cycle delayed copy.
  - A held-high level is one event only.
  - inta falling edge is also detected.
- Init FSM states: UNINIT, W_ICW2, W_ICW3, W_ICW4, READY.
- ICW1 = write with a0=0 and D[4]=1; accepted in any state. Effects:
  - LTIM<=D[3], single<=D[1], ic4<=D[0].
  - buff<=0, ar<=0, ino<=0, int<=0, INTA FSM -> IDLE.
  - Next state W_ICW2.
- W_ICW2: write with a0=1 -> W_ICW3 if single=0; else W_ICW4 if ic4=1; else READY.
- W_ICW3: write with a0=1 -> W_ICW4 if ic4=1, else READY.
- W_ICW4: write with a0=1 -> buff<=D[3], ar<=D[1], then READY.
- Writes with a0=0 and D[4]=0 in the W_ICW* states are ignored.
- ino=1 exactly when the state is READY.
- UNINIT ignores all writes except ICW1.
- OCW2 in READY (a0=0, D[4:3]=00, D[5]=1, covering non-specific and specific EOI): eoi=1 for exactly one cycle on the next edge.
- All other OCWs produce no output change here.
- int <= ino & isprior & |(irr & ~Mask) while the INTA FSM is IDLE; otherwise 0.
- INTA FSM states: IDLE, ACK1, ACK2.
  - IDLE: inta rising -> ACK1; int<=0; Y captured.
  - ACK1: next inta rising -> ACK2.
  - ACK2: inta falling -> IDLE; if ar=1, eoi=1 for one cycle.
  - In ACK1/ACK2, inta rising is ignored unless the FSM is in ACK1.
- en = 1 in either case:
  - INTA FSM in ACK2 with inta=1, and (single=1, or S=1, or S=0 & CLsig=1); or
  - rdflag=1 and ino=1.
- Otherwise en=0.
- If inta rises while ino=0, it is ignored.
- Simultaneous wrflg and inta rising edges: the write is processed first; an ICW1 aborts the acknowledge.
- isr is a status input only; no output depends on it in this revision.

Decomposition:
- Shared package pic_pkg holds:
  - init and INTA state enums;
  - ICW1/OCW2 decode bit-position constants (IC4=0, SNGL=1, LTIM=3, ICW1_ID=4, EOI=5);
  - ICW4 constants (AEOI=1, BUF=3).
- One natural sub-module: pic_edge_detect, a rising/falling strobe detector instantiated for wrflg and inta.

Test Plan:
- No init, with reset high: inta=1, wrflg=1, a0=0, D=0xAA, S=1, isr=0xAA -> all outputs stay 0 (D[4]=0 is not ICW1).
- ICW1=0x1B, ICW2=0x20, ICW4=0x0B (each a0=1 where required, single mode) -> LTIM=1, buff=1, ar=1, ino=1 after the ICW4 edge; ICW3 skipped.
- Operational, irr=0x04, Mask=0x00, isprior=1 -> int=1 next edge; Mask=0x04 -> int=0.
- int=1, two inta pulses, S=1, ar=1 -> int=0 after first rising edge, en=1 only during the second pulse, eoi single-cycle pulse after second falling edge.
- Operational, write a0=0, D=0x20 -> eoi=1 for one cycle; slave S=0, CLsig=0 during ACK2 -> en=0.
- Reset low mid-INTA (state ACK1) -> next edge: all outputs 0, ino=0, following inta ignored.
